// File: rtl/gray_pkg.sv
// Shared Gray-code helpers for the cross-domain pointer receiver and its benches.
// Functions work on a wide vector; zero-extension leaves every result unchanged.
package gray_pkg;

    localparam int DEFAULT_WIDTH = 3;
    localparam int MAX_WIDTH     = 32;

    typedef logic [MAX_WIDTH-1:0] gvec_t;

    function automatic gvec_t gray2bin(input gvec_t g);
        gvec_t b;
        b[MAX_WIDTH-1] = g[MAX_WIDTH-1];
        for (int i = MAX_WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic gvec_t bin2gray(input gvec_t b);
        return b ^ (b >> 1);
    endfunction

    // True when exactly one bit is set.
    function automatic logic onehot_diff(input gvec_t d);
        return (d != '0) && ((d & (d - gvec_t'(1))) == '0);
    endfunction

endpackage

// File: rtl/gray_to_binary.sv
// Combinational Gray-to-binary inverse of the upstream binary-to-Gray stage.
module gray_to_binary
    import gray_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] g,
    output logic [WIDTH-1:0] b
);

    always_comb begin
        // NOTE: default assignment first so no path leaves b unassigned (no latch).
        b = '0;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
    end

endmodule

// File: rtl/gray_sync_decoder.sv
// Synchronises a foreign-domain Gray count into clk, decodes it to binary and
// reports legal single steps (with direction) or illegal multi-bit jumps.
module gray_sync_decoder
    import gray_pkg::*;
#(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] g_in,
    input  logic             err_clr,
    output logic [WIDTH-1:0] g_sync,
    output logic [WIDTH-1:0] b_out,
    output logic             upd,
    output logic             dir,
    output logic             illegal,
    output logic             err_sticky
);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] g_prev;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] b_new;
    logic             step;
    logic             jump;

    // Plain flop chain: no logic between stages so metastability can settle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the chain is a handful of flops, not RAM, so it is reset explicitly.
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking so each stage captures its predecessor's old value.
            sync_q[0] <= g_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign g_sync = sync_q[SYNC_STAGES-1];
    assign diff   = g_sync ^ g_prev;
    assign step   = onehot_diff(gvec_t'(diff));
    assign jump   = (diff != '0) && !step;

    gray_to_binary #(.WIDTH(WIDTH)) u_g2b (
        .g (g_sync),
        .b (b_new)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            g_prev     <= '0;
            b_out      <= '0;
            upd        <= 1'b0;
            dir        <= 1'b0;
            illegal    <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            upd     <= step;
            illegal <= jump;
            // An illegal jump still resyncs to the observed value.
            if (step || jump) begin
                g_prev <= g_sync;
                b_out  <= b_new;
            end
            if (step) begin
                dir <= (b_new == b_out + WIDTH'(1));
            end
            if (jump) begin
                err_sticky <= 1'b1;
            end else if (err_clr) begin
                err_sticky <= 1'b0;
            end
        end
    end

endmodule
